// File: rtl/prng_p2s.sv
// UART-style serialiser for PRNG words: start, data MSB-first, optional
// even parity, stop. A one-word holding register decouples PRNG and line.
module prng_p2s #(
    parameter int WIDTH        = 32,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             load,
    output logic             ready,
    output logic             sout,
    output logic             sframe,
    output logic             bit_stb,
    output logic             overflow,
    output logic [15:0]      words_sent
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] hold;
    logic             hold_full;
    logic [WIDTH-1:0] shift;
    logic             par;
    logic [CW-1:0]    cyc_cnt;
    logic [BW-1:0]    bit_cnt;
    logic             last_cyc;
    logic             last_bit;
    logic             take;
    logic             accept;

    assign last_cyc = (cyc_cnt == CYC_LAST);
    assign last_bit = (bit_cnt == BIT_LAST);
    assign accept   = load && !hold_full;
    assign ready    = !hold_full;

    // The hold word moves into the shifter from IDLE, or on the last stop
    // cycle so consecutive frames abut without an idle gap.
    assign take = hold_full &&
                  ((state == IDLE) || ((state == STOP) && last_cyc));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            hold       <= '0;
            hold_full  <= 1'b0;
            shift      <= '0;
            par        <= 1'b0;
            cyc_cnt    <= '0;
            bit_cnt    <= '0;
            overflow   <= 1'b0;
            words_sent <= '0;
        end else begin
            state <= state_nxt;

            if (accept) begin
                hold      <= din;
                hold_full <= 1'b1;
            end else if (take) begin
                hold_full <= 1'b0;
            end

            if (load && hold_full) begin
                overflow <= 1'b1;
            end

            if (take) begin
                shift <= hold;
                par   <= ^hold;
            end else if ((state == DATA) && last_cyc) begin
                shift <= shift << 1;
            end

            if (state_nxt != state) begin
                cyc_cnt <= '0;
                bit_cnt <= '0;
            end else if (last_cyc) begin
                cyc_cnt <= '0;
                if (state == DATA) begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end else begin
                cyc_cnt <= cyc_cnt + 1'b1;
            end

            if ((state == STOP) && last_cyc) begin
                words_sent <= words_sent + 16'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (hold_full) state_nxt = START;
            end
            START: begin
                if (last_cyc) state_nxt = DATA;
            end
            DATA: begin
                if (last_cyc && last_bit) begin
                    state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (last_cyc) state_nxt = STOP;
            end
            STOP: begin
                if (last_cyc) state_nxt = hold_full ? START : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        sout    = 1'b1;
        sframe  = 1'b1;
        bit_stb = 1'b0;
        unique case (state)
            IDLE: begin
                sframe = 1'b0;
            end
            START: begin
                sout = 1'b0;
            end
            DATA: begin
                sout    = shift[WIDTH-1];
                bit_stb = (cyc_cnt == '0);
            end
            PARITY: begin
                sout = par;
            end
            STOP: begin
                sout = 1'b1;
            end
            default: begin
                sframe = 1'b0;
            end
        endcase
    end

endmodule
